// File: rtl/spi_master_arbiter_if.sv
// spi_master_arbiter_if: requester streams, SPI master channel and status of the arbiter
interface spi_master_arbiter_if #(
    parameter int N = 3,
    parameter int W = 32
);
    logic [N-1:0]         req_val;
    logic [N-1:0]         req_rdy;
    logic [N*W-1:0]       req_msg;
    logic [N-1:0]         resp_val;
    logic [N-1:0]         resp_rdy;
    logic [W-1:0]         resp_msg;
    logic                 resp_err;
    logic                 spi_req_val;
    logic                 spi_req_rdy;
    logic [W-1:0]         spi_req_msg;
    logic                 spi_resp_val;
    logic                 spi_resp_rdy;
    logic [W-1:0]         spi_resp_msg;
    logic [$clog2(N)-1:0] grant;
    logic                 busy;

    modport master (
        input  req_val, req_msg, resp_rdy, spi_req_rdy, spi_resp_val, spi_resp_msg,
        output req_rdy, resp_val, resp_msg, resp_err, spi_req_val, spi_req_msg,
               spi_resp_rdy, grant, busy
    );

    modport slave (
        output req_val, req_msg, resp_rdy, spi_req_rdy, spi_resp_val, spi_resp_msg,
        input  req_rdy, resp_val, resp_msg, resp_err, spi_req_val, spi_req_msg,
               spi_resp_rdy, grant, busy
    );
endinterface

// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter: round-robin sharing of one SPI master channel with response timeout
module spi_master_arbiter #(
    parameter int N       = 3,
    parameter int W       = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    spi_master_arbiter_if.master  bus
);
    localparam int GW = $clog2(N);
    localparam int TW = $clog2(TIMEOUT + 2);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RETURN} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [GW-1:0] r_ptr;
    logic [GW-1:0] r_grant;
    logic [GW-1:0] w_win;
    logic          w_found;
    logic          w_tmo;
    logic [W-1:0]  r_req_buf;
    logic [W-1:0]  r_resp_buf;
    logic          r_err;
    logic [TW-1:0] r_timer;

    function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        return GW'(s >= N ? s - N : s);
    endfunction

    // Scan from the pointer downward in priority so the nearest requester after ptr wins
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (bus.req_val[rr_idx(r_ptr, k)]) begin
                w_win   = rr_idx(r_ptr, k);
                w_found = 1'b1;
            end
        end
    end

    assign w_tmo = (TIMEOUT != 0) && (r_timer == TLAST);

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Request/response buffers, grant pointer and wait timer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr      <= '0;
            r_grant    <= '0;
            r_timer    <= '0;
            r_req_buf  <= '0;
            r_resp_buf <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_found) begin
                    r_req_buf <= bus.req_msg[w_win*W +: W];
                    r_grant   <= w_win;
                    r_ptr     <= (w_win == GW'(N - 1)) ? '0 : w_win + 1'b1;
                end
                ISSUE: if (bus.spi_req_rdy) r_timer <= '0;
                WAIT: begin
                    if (bus.spi_resp_val) begin
                        r_resp_buf <= bus.spi_resp_msg;
                        r_err      <= 1'b0;
                    end else if (w_tmo) begin
                        r_resp_buf <= '0;
                        r_err      <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state and handshake outputs; a real response beats a same-cycle timeout
    always_comb begin
        w_next           = r_state;
        bus.req_rdy      = '0;
        bus.resp_val     = '0;
        bus.spi_req_val  = 1'b0;
        bus.spi_resp_rdy = 1'b0;
        case (r_state)
            IDLE: begin
                bus.spi_resp_rdy = 1'b1;
                bus.req_rdy      = (w_found && !reset) ? N'(1) << w_win : '0;
                if (w_found) w_next = ISSUE;
            end
            ISSUE: begin
                bus.spi_req_val = 1'b1;
                if (bus.spi_req_rdy) w_next = WAIT;
            end
            WAIT: begin
                bus.spi_resp_rdy = 1'b1;
                if (bus.spi_resp_val || w_tmo) w_next = RETURN;
            end
            RETURN: begin
                bus.resp_val = N'(1) << r_grant;
                if (bus.resp_rdy[r_grant]) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign bus.resp_msg    = r_resp_buf;
    assign bus.resp_err    = r_err;
    assign bus.spi_req_msg = r_req_buf;
    assign bus.grant       = r_grant;
    assign bus.busy        = (r_state != IDLE);
endmodule

// File: tb/tb_spi_master_arbiter.sv
// tb_spi_master_arbiter: directed checks of arbitration, latency, backpressure, timeout and reset
module tb_spi_master_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    int          total = 0;
    int          bad = 0;
    logic [31:0] msgs [3];

    spi_master_arbiter_if #(.N(3), .W(32)) bus();

    spi_master_arbiter #(.N(3), .W(32), .TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete transaction for requester g, already requesting, in IDLE
    task automatic txn(input int g, input logic [31:0] rsp);
        #1;
        chk("txn_req_rdy", 32'(bus.req_rdy), 32'(1 << g));
        step();
        chk("txn_grant", 32'(bus.grant), 32'(g));
        chk("txn_spi_req_msg", bus.spi_req_msg, msgs[g]);
        chk("txn_spi_req_val", 32'(bus.spi_req_val), 32'd1);
        bus.spi_req_rdy = 1'b1;
        step();
        bus.spi_req_rdy  = 1'b0;
        bus.spi_resp_val = 1'b1;
        bus.spi_resp_msg = rsp;
        step();
        bus.spi_resp_val = 1'b0;
        chk("txn_resp_val", 32'(bus.resp_val), 32'(1 << g));
        chk("txn_resp_msg", bus.resp_msg, rsp);
        chk("txn_resp_err", 32'(bus.resp_err), 32'd0);
        bus.resp_rdy = 3'b111;
        step();
        bus.resp_rdy = 3'b000;
    endtask

    initial begin
        msgs = '{32'h1111_1111, 32'hDEAD_BEEF, 32'h3333_3333};
        reset            = 1'b1;
        bus.req_val      = 3'b000;
        bus.req_msg      = {msgs[2], msgs[1], msgs[0]};
        bus.resp_rdy     = 3'b000;
        bus.spi_req_rdy  = 1'b0;
        bus.spi_resp_val = 1'b0;
        bus.spi_resp_msg = 32'h0;
        step();
        step();
        reset = 1'b0;
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_req_rdy", 32'(bus.req_rdy), 32'd0);
        chk("rst_resp_val", 32'(bus.resp_val), 32'd0);
        chk("rst_resp_msg", bus.resp_msg, 32'd0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst_spi_req_val", 32'(bus.spi_req_val), 32'd0);
        chk("rst_grant", 32'(bus.grant), 32'd0);

        // Single request from requester 1, reply in the third WAIT cycle
        bus.req_val = 3'b010;
        #1;
        chk("s_req_rdy", 32'(bus.req_rdy), 32'b010);
        step();
        bus.req_val = 3'b000;
        chk("s_spi_req_val", 32'(bus.spi_req_val), 32'd1);
        chk("s_spi_req_msg", bus.spi_req_msg, 32'hDEAD_BEEF);
        chk("s_grant", 32'(bus.grant), 32'd1);
        chk("s_busy", 32'(bus.busy), 32'd1);
        bus.spi_req_rdy = 1'b1;
        step();
        bus.spi_req_rdy = 1'b0;
        step();
        step();
        bus.spi_resp_val = 1'b1;
        bus.spi_resp_msg = 32'h0000_CAFE;
        #1;
        chk("s_spi_resp_rdy_wait", 32'(bus.spi_resp_rdy), 32'd1);
        step();
        bus.spi_resp_val = 1'b0;
        chk("s_resp_val", 32'(bus.resp_val), 32'b010);
        chk("s_resp_msg", bus.resp_msg, 32'h0000_CAFE);
        chk("s_resp_err", 32'(bus.resp_err), 32'd0);
        chk("s_spi_resp_rdy_ret", 32'(bus.spi_resp_rdy), 32'd0);
        bus.resp_rdy = 3'b010;
        step();
        bus.resp_rdy = 3'b000;
        chk("s_busy_after", 32'(bus.busy), 32'd0);
        chk("s_resp_val_after", 32'(bus.resp_val), 32'd0);
        chk("s_resp_msg_hold", bus.resp_msg, 32'h0000_CAFE);

        // Round-robin with all requesters active from reset
        bus.req_val = 3'b111;
        reset = 1'b1;
        step();
        reset = 1'b0;
        txn(0, 32'hA000_0000);
        txn(1, 32'hA000_0001);
        txn(2, 32'hA000_0002);
        txn(0, 32'hA000_0003);
        bus.req_val = 3'b101;
        txn(2, 32'hA000_0004);
        txn(0, 32'hA000_0005);
        bus.req_val = 3'b000;

        // Backpressure: SPI stalls the request, then requester 0 stalls the response
        bus.req_val = 3'b001;
        #1;
        chk("bp_req_rdy", 32'(bus.req_rdy), 32'b001);
        step();
        bus.req_val = 3'b110;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_spi_req_val", 32'(bus.spi_req_val), 32'd1);
            chk("bp_spi_req_msg", bus.spi_req_msg, msgs[0]);
            chk("bp_req_rdy_issue", 32'(bus.req_rdy), 32'd0);
            step();
        end
        bus.spi_req_rdy = 1'b1;
        step();
        bus.spi_req_rdy  = 1'b0;
        bus.spi_resp_val = 1'b1;
        bus.spi_resp_msg = 32'h0000_0055;
        step();
        bus.spi_resp_val = 1'b0;
        bus.resp_rdy     = 3'b110;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_resp_val_hold", 32'(bus.resp_val), 32'b001);
            chk("bp_grant_hold", 32'(bus.grant), 32'd0);
            chk("bp_req_rdy_ret", 32'(bus.req_rdy), 32'd0);
            step();
        end
        bus.resp_rdy = 3'b001;
        step();
        bus.resp_rdy = 3'b000;
        #1;
        chk("bp_next_winner", 32'(bus.req_rdy), 32'b010);
        bus.req_val = 3'b000;

        // Timeout on requester 2, then a late response drained in IDLE
        bus.req_val = 3'b100;
        #1;
        chk("to_req_rdy", 32'(bus.req_rdy), 32'b100);
        step();
        bus.req_val     = 3'b000;
        bus.spi_req_rdy = 1'b1;
        step();
        bus.spi_req_rdy = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("to_wait_no_resp", 32'(bus.resp_val), 32'd0);
            step();
        end
        chk("to_resp_val", 32'(bus.resp_val), 32'b100);
        chk("to_resp_msg", bus.resp_msg, 32'd0);
        chk("to_resp_err", 32'(bus.resp_err), 32'd1);
        bus.resp_rdy = 3'b100;
        step();
        bus.resp_rdy     = 3'b000;
        bus.spi_resp_val = 1'b1;
        bus.spi_resp_msg = 32'h0000_0BAD;
        #1;
        chk("late_spi_resp_rdy", 32'(bus.spi_resp_rdy), 32'd1);
        step();
        bus.spi_resp_val = 1'b0;
        chk("late_busy", 32'(bus.busy), 32'd0);
        chk("late_resp_val", 32'(bus.resp_val), 32'd0);
        bus.req_val = 3'b001;
        txn(0, 32'h0000_1234);
        bus.req_val = 3'b000;

        // Response arrives in the very cycle the timer expires
        bus.req_val = 3'b010;
        #1;
        step();
        bus.req_val     = 3'b000;
        bus.spi_req_rdy = 1'b1;
        step();
        bus.spi_req_rdy = 1'b0;
        for (int i = 0; i < 15; i++) step();
        bus.spi_resp_val = 1'b1;
        bus.spi_resp_msg = 32'h7777_0001;
        step();
        bus.spi_resp_val = 1'b0;
        chk("tie_resp_val", 32'(bus.resp_val), 32'b010);
        chk("tie_resp_err", 32'(bus.resp_err), 32'd0);
        chk("tie_resp_msg", bus.resp_msg, 32'h7777_0001);
        bus.resp_rdy = 3'b010;
        step();
        bus.resp_rdy = 3'b000;

        // Reset pulse in the middle of WAIT abandons the transaction
        bus.req_val = 3'b010;
        #1;
        chk("mr_req_rdy", 32'(bus.req_rdy), 32'b010);
        step();
        bus.req_val     = 3'b000;
        bus.spi_req_rdy = 1'b1;
        step();
        bus.spi_req_rdy = 1'b0;
        step();
        chk("mr_grant_before", 32'(bus.grant), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mr_busy", 32'(bus.busy), 32'd0);
        chk("mr_resp_val", 32'(bus.resp_val), 32'd0);
        chk("mr_spi_req_val", 32'(bus.spi_req_val), 32'd0);
        chk("mr_grant", 32'(bus.grant), 32'd0);
        chk("mr_resp_msg", bus.resp_msg, 32'd0);
        bus.spi_resp_val = 1'b1;
        bus.spi_resp_msg = 32'h0000_0DEF;
        step();
        bus.spi_resp_val = 1'b0;
        chk("mr_no_resp", 32'(bus.resp_val), 32'd0);
        bus.req_val = 3'b101;
        #1;
        chk("mr_ptr_zero", 32'(bus.req_rdy), 32'b001);
        bus.req_val = 3'b100;
        txn(2, 32'h0000_2222);
        bus.req_val = 3'b000;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
